// File: rtl/matrix_pkg.sv
// Shared types and helpers for the matrix result serializer.
package matrix_pkg;

  typedef enum logic [1:0] {IDLE, SEND, DONE} ser_state_t;

  localparam int DATA_W = 64;

  function automatic int idx_w(input int n);
    return ($clog2(n) < 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/matrix_result_serializer_rise_detect.sv
// 1-bit registered rising-edge detector; the history bit clears on reset so a
// level already high at reset release reports an edge.
module rise_detect (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic rise
);

  logic d_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) d_q <= 1'b0;
    else        d_q <= d;
  end

  assign rise = d & ~d_q;

endmodule

// File: rtl/matrix_result_serializer.sv
// Captures the M x P result matrix on a rising mult_ready and streams it out
// row-major over valid/ready. Optional trailing checksum beat: MATRIX_SER_CHECKSUM_EN.
//
// state | meaning
// IDLE  | waiting for a mult_ready rising edge
// SEND  | streaming snapshot elements (and checksum beat when enabled)
// DONE  | one-cycle done pulse, then back to IDLE
module matrix_result_serializer
  import matrix_pkg::*;
#(
  parameter int M = 2,
  parameter int P = 2,
  localparam int RW = idx_w(M),
  localparam int CW = idx_w(P)
) (
  input  logic                                  clk,
  input  logic                                  reset,
  input  logic [M-1:0][P-1:0][DATA_W-1:0]       array_c,
  input  logic                                  mult_ready,
  output logic [DATA_W-1:0]                     out_data,
  output logic [RW-1:0]                         out_row,
  output logic [CW-1:0]                         out_col,
  output logic                                  out_valid,
  input  logic                                  out_ready,
  output logic                                  out_last,
  output logic                                  out_is_chk,
  output logic                                  busy,
  output logic                                  done
);

  localparam logic [RW-1:0] ROW_MAX = RW'(M - 1);
  localparam logic [CW-1:0] COL_MAX = CW'(P - 1);

  ser_state_t                          state_q, state_d;
  logic [RW-1:0]                       row_q;
  logic [CW-1:0]                       col_q;
  logic [M-1:0][P-1:0][DATA_W-1:0]     snap_q;
  logic                                rise;
  logic                                capture, hs, elem_hs, elem_last;
  logic                                is_chk, final_beat;
  logic [DATA_W-1:0]                   sum_val;

  rise_detect u_rise (
    .clk   (clk),
    .reset (reset),
    .d     (mult_ready),
    .rise  (rise)
  );

  assign capture   = (state_q == IDLE) & rise;
  assign hs        = (state_q == SEND) & out_ready;
  assign elem_hs   = hs & ~is_chk;
  assign elem_last = (row_q == ROW_MAX) && (col_q == COL_MAX);

`ifdef MATRIX_SER_CHECKSUM_EN
  logic              chk_q;
  logic [DATA_W-1:0] sum_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      chk_q <= 1'b0;
      sum_q <= '0;
    end else if (capture) begin
      chk_q <= 1'b0;
      sum_q <= '0;
    end else if (elem_hs) begin
      sum_q <= sum_q + snap_q[row_q][col_q];
      if (elem_last) chk_q <= 1'b1;
    end
  end

  assign is_chk     = chk_q;
  assign sum_val    = sum_q;
  assign final_beat = chk_q;
`else
  assign is_chk     = 1'b0;
  assign sum_val    = '0;
  assign final_beat = elem_last;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      row_q   <= '0;
      col_q   <= '0;
      snap_q  <= '0;
    end else begin
      state_q <= state_d;
      if (capture) begin
        snap_q <= array_c;
        row_q  <= '0;
        col_q  <= '0;
      end else if (elem_hs) begin
        if (col_q == COL_MAX) begin
          col_q <= '0;
          row_q <= row_q + RW'(1);
        end else begin
          col_q <= col_q + CW'(1);
        end
      end
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (rise) state_d = SEND;
      SEND:    if (hs && final_beat) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Outputs decode straight from registered state so reset clears them at once.
  always_comb begin
    out_valid  = 1'b0;
    busy       = 1'b0;
    done       = 1'b0;
    out_data   = '0;
    out_row    = '0;
    out_col    = '0;
    out_last   = 1'b0;
    out_is_chk = 1'b0;
    case (state_q)
      SEND: begin
        out_valid  = 1'b1;
        busy       = 1'b1;
        out_last   = final_beat;
        out_is_chk = is_chk;
        if (is_chk) begin
          out_data = sum_val;
        end else begin
          out_data = snap_q[row_q][col_q];
          out_row  = row_q;
          out_col  = col_q;
        end
      end
      DONE:    done = 1'b1;
      default: ;
    endcase
  end

endmodule
